// File: rtl/ysyx_23060077_id_imm_pipe.sv
// Immediate-decode pipeline stage between IF and ID: decodes the immediate and its
// format, then presents {inst, pc, imm, type} through a two-entry skid buffer.
module ysyx_23060077_id_imm_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic [PC_WIDTH-1:0]   in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [2:0]            out_type
);

    typedef enum logic [2:0] {
        T_NONE = 3'd0,
        T_I    = 3'd1,
        T_S    = 3'd2,
        T_B    = 3'd3,
        T_U    = 3'd4,
        T_J    = 3'd5,
        T_Z    = 3'd6
    } imm_type_e;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_SYS       = 7'b1110011;

    // Returns {type, imm}; $signed + size cast performs the sign extension to XLEN.
    function automatic logic [DATA_WIDTH+2:0] decode(input logic [31:0] inst);
        logic [DATA_WIDTH-1:0] imm;
        logic [2:0]            typ;
        imm = '0;
        typ = T_NONE;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                imm = DATA_WIDTH'($signed({inst[31:12], 12'b0}));
                typ = T_U;
            end
            OPC_JAL: begin
                imm = DATA_WIDTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
                typ = T_J;
            end
            OPC_BRANCH: begin
                imm = DATA_WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
                typ = T_B;
            end
            OPC_STORE: begin
                imm = DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
                typ = T_S;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                imm = DATA_WIDTH'($signed(inst[31:20]));
                typ = T_I;
            end
            OPC_SYS: begin
                if (inst[14:12] == 3'b101 || inst[14:12] == 3'b110 || inst[14:12] == 3'b111) begin
                    imm = DATA_WIDTH'(inst[19:15]);
                    typ = T_Z;
                end else begin
                    imm = DATA_WIDTH'($signed(inst[31:20]));
                    typ = T_I;
                end
            end
            OPC_OP_IMM_32: begin
                if (DATA_WIDTH == 64) begin
                    imm = DATA_WIDTH'($signed(inst[31:20]));
                    typ = T_I;
                end else begin
                    imm = '0;
                    typ = T_NONE;
                end
            end
            default: begin
                imm = '0;
                typ = T_NONE;
            end
        endcase
        return {typ, imm};
    endfunction

    logic                  r_m_valid;
    logic [INST_WIDTH-1:0] r_m_inst;
    logic [PC_WIDTH-1:0]   r_m_pc;
    logic [DATA_WIDTH-1:0] r_m_imm;
    logic [2:0]            r_m_type;
    logic                  r_k_valid;
    logic [INST_WIDTH-1:0] r_k_inst;
    logic [PC_WIDTH-1:0]   r_k_pc;
    logic [DATA_WIDTH-1:0] r_k_imm;
    logic [2:0]            r_k_type;

    logic [DATA_WIDTH+2:0] w_dec;
    logic                  w_accept;
    logic                  w_pop;

    assign w_dec    = decode(in_inst[31:0]);
    // Ready is a pure function of the skid register; gated by reset so it reads 0 while held.
    assign in_ready = reset_n & ~r_k_valid;
    assign w_accept = in_valid & in_ready;
    assign w_pop    = r_m_valid & out_ready;

    assign out_valid = r_m_valid;
    assign out_inst  = r_m_inst;
    assign out_pc    = r_m_pc;
    assign out_imm   = r_m_imm;
    assign out_type  = r_m_type;

    // Main/skid entry update: flush first, then refill M from K (older) or from the input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_m_valid <= 1'b0;
            r_m_inst  <= '0;
            r_m_pc    <= '0;
            r_m_imm   <= '0;
            r_m_type  <= 3'd0;
            r_k_valid <= 1'b0;
            r_k_inst  <= '0;
            r_k_pc    <= '0;
            r_k_imm   <= '0;
            r_k_type  <= 3'd0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_k_valid <= 1'b0;
        end else if (!r_m_valid || w_pop) begin
            if (r_k_valid) begin
                r_m_valid <= 1'b1;
                r_m_inst  <= r_k_inst;
                r_m_pc    <= r_k_pc;
                r_m_imm   <= r_k_imm;
                r_m_type  <= r_k_type;
                r_k_valid <= 1'b0;
            end else begin
                r_m_valid <= w_accept;
                if (w_accept) begin
                    r_m_inst <= in_inst;
                    r_m_pc   <= in_pc;
                    r_m_imm  <= w_dec[DATA_WIDTH-1:0];
                    r_m_type <= w_dec[DATA_WIDTH+2:DATA_WIDTH];
                end
            end
        end else if (w_accept) begin
            r_k_valid <= 1'b1;
            r_k_inst  <= in_inst;
            r_k_pc    <= in_pc;
            r_k_imm   <= w_dec[DATA_WIDTH-1:0];
            r_k_type  <= w_dec[DATA_WIDTH+2:DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_id_imm_pipe.sv
// Scoreboard bench: RV32 and RV64 instances share stimulus; a reference decoder
// computes immediates arithmetically and a monitor checks every output handshake.
module tb_ysyx_23060077_id_imm_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        rdy32, rdy64, v32, v64;
    logic [31:0] inst32, inst64, pc32, pc64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  t32, t64;

    int checks = 0;
    int errors = 0;
    int pop_count = 0;

    always #5 clock = ~clock;

    ysyx_23060077_id_imm_pipe #(.DATA_WIDTH(32), .INST_WIDTH(32), .PC_WIDTH(32)) u_dut32 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(v32), .out_ready(out_ready), .out_inst(inst32), .out_pc(pc32),
        .out_imm(imm32), .out_type(t32));

    ysyx_23060077_id_imm_pipe #(.DATA_WIDTH(64), .INST_WIDTH(32), .PC_WIDTH(32)) u_dut64 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(v64), .out_ready(out_ready), .out_inst(inst64), .out_pc(pc64),
        .out_imm(imm64), .out_type(t64));

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  t32;
        logic [2:0]  t64;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint fld(input longint unsigned u, input int hi, input int lo);
        return longint'((u >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1));
    endfunction

    function automatic longint sext(input longint v, input int bits);
        return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
    endfunction

    // Reference decoder: reassemble each immediate numerically from its fields.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t          e;
        longint unsigned u;
        longint        v;
        logic [63:0]   vv;
        int            op, t;
        u = longint'(inst);
        op = int'(fld(u, 6, 0));
        v = 0;
        t = 0;
        case (op)
            'h37, 'h17: begin t = 4; v = sext(fld(u, 31, 12) * 4096, 32); end
            'h6f: begin
                t = 5;
                v = sext(fld(u, 31, 31) * (1 << 20) + fld(u, 19, 12) * (1 << 12)
                         + fld(u, 20, 20) * (1 << 11) + fld(u, 30, 21) * 2, 21);
            end
            'h63: begin
                t = 3;
                v = sext(fld(u, 31, 31) * 4096 + fld(u, 7, 7) * 2048
                         + fld(u, 30, 25) * 32 + fld(u, 11, 8) * 2, 13);
            end
            'h23: begin t = 2; v = sext(fld(u, 31, 25) * 32 + fld(u, 11, 7), 12); end
            'h67, 'h03, 'h13, 'h1b: begin t = 1; v = sext(fld(u, 31, 20), 12); end
            'h73: begin
                if (fld(u, 14, 12) >= 5) begin t = 6; v = fld(u, 19, 15); end
                else begin t = 1; v = sext(fld(u, 31, 20), 12); end
            end
            default: begin t = 0; v = 0; end
        endcase
        vv = v;
        e.inst  = inst;
        e.pc    = pc;
        e.imm64 = vv;
        e.t64   = 3'(t);
        if (op == 'h1b) begin
            e.imm32 = 32'd0;
            e.t32   = 3'd0;
        end else begin
            e.imm32 = vv[31:0];
            e.t32   = 3'(t);
        end
        return e;
    endfunction

    // Recorder: every accepted, non-flushed input yields one expected output.
    always @(negedge clock) begin
        if (reset_n && in_valid && rdy32 && !flush)
            sb.push_back(model(in_inst, in_pc));
    end

    logic        h_valid = 1'b0;
    logic [31:0] h_inst, h_pc, h_imm32;
    logic [63:0] h_imm64;

    // Monitor: pops on each output handshake, checks hold stability under backpressure.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            sb.delete();
            h_valid = 1'b0;
        end else begin
            if (h_valid)
                chk("hold", {v32, inst32, pc32, imm32, imm64[31:0]},
                    {1'b1, h_inst, h_pc, h_imm32, h_imm64[31:0]});
            if (v32 && out_ready && !flush) begin
                pop_count++;
                if (sb.size() == 0) begin
                    chk("spurious_out", {96'd0, inst32}, 128'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out32", {29'd0, v32, inst32, pc32, t32, imm32},
                        {29'd0, 1'b1, e.inst, e.pc, e.t32, e.imm32});
                    chk("out64", {v64, inst64, t64, imm64}, {1'b1, e.inst, e.t64, e.imm64});
                end
            end
            h_valid = v32 && !out_ready && !flush;
            h_inst  = inst32;
            h_pc    = pc32;
            h_imm32 = imm32;
            h_imm64 = imm64;
            if (flush) sb.delete();
        end
    end

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        logic acc;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        acc      = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clock);
            acc = rdy32;
            @(posedge clock);
            #1;
        end
        if (!acc) chk("send_timeout", 128'd0, 128'd1);
        in_valid = 1'b0;
    endtask

    logic [31:0] d_inst  [8] = '{32'hFFF00093, 32'h80000537, 32'hFE000EE3, 32'h0040006F,
                                 32'h3050D073, 32'h0000003B, 32'h8000101B, 32'h0000100F};
    logic [63:0] d_imm64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC,
                                 64'h4, 64'h1, 64'h0, 64'hFFFFFFFFFFFFF800, 64'h0};
    logic [2:0]  d_t64   [8] = '{3'd1, 3'd4, 3'd3, 3'd5, 3'd6, 3'd0, 3'd1, 3'd0};
    logic [31:0] d_imm32 [8] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFC, 32'h4, 32'h1,
                                 32'h0, 32'h0, 32'h0};
    logic [2:0]  d_t32   [8] = '{3'd1, 3'd4, 3'd3, 3'd5, 3'd6, 3'd0, 3'd0, 3'd0};
    logic [6:0]  ops     [13] = '{7'h37, 7'h17, 7'h6f, 7'h63, 7'h23, 7'h67, 7'h03,
                                  7'h13, 7'h73, 7'h1b, 7'h33, 7'h0f, 7'h3b};

    initial begin
        logic        acc;
        logic [31:0] r;
        int          p0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", {v32, v64, rdy32, rdy64, inst32, pc32, imm32, t32, t64},
            {4'b0000, 96'd0, 3'd0, 3'd0});
        chk("reset_imm64", {64'd0, imm64}, 128'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("ready_after_reset", {126'd0, rdy32, rdy64}, {126'd0, 2'b11});

        // Directed decode table, one at a time through an empty stage.
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(d_inst[i], 32'h1000 + 32'(i * 4));
            chk("latency1_imm32", {92'd0, v32, t32, imm32}, {92'd0, 1'b1, d_t32[i], d_imm32[i]});
            chk("latency1_imm64", {60'd0, v64, t64, imm64}, {60'd0, 1'b1, d_t64[i], d_imm64[i]});
            @(posedge clock);
            #1;
        end

        // Backpressure: A and B fill M and K, C waits upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00100093;
        in_pc     = 32'h2000;
        @(posedge clock); #1;
        in_inst = 32'h00200113;
        in_pc   = 32'h2004;
        @(posedge clock); #1;
        chk("abc_full", {95'd0, rdy32, v32, inst32}, {95'd0, 1'b0, 1'b1, 32'h00100093});
        in_inst = 32'h00300193;
        in_pc   = 32'h2008;
        @(posedge clock); #1;
        chk("abc_c_held", {126'd0, rdy32, v32}, {126'd0, 2'b01});
        p0 = pop_count;
        out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock); #1;
        chk("abc_throughput", 128'(pop_count - p0), 128'd3);

        // Randomized traffic with backpressure and occasional flush.
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            acc = in_valid && rdy32;
            @(posedge clock); #1;
            if (!in_valid || acc || flush) begin
                r        = $urandom();
                in_valid = ($urandom_range(0, 3) != 0);
                in_inst  = {r[31:7], ops[$urandom_range(0, 12)]};
                in_pc    = $urandom();
            end
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 24) == 0);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;

        // Flush from FULL with a live input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00400213;
        @(posedge clock); #1;
        in_inst = 32'h00500293;
        @(posedge clock); #1;
        chk("full_before_flush", {126'd0, rdy32, v32}, {126'd0, 2'b01});
        flush   = 1'b1;
        in_inst = 32'h00600313;
        @(posedge clock); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_full", {124'd0, v32, v64, rdy32, rdy64}, {124'd0, 4'b0011});

        // Flush from M-only: the input offered while ready must be dropped.
        in_valid = 1'b1;
        in_inst  = 32'h00700393;
        @(posedge clock); #1;
        flush   = 1'b1;
        in_inst = 32'h00800413;
        @(posedge clock); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_m_only", {126'd0, v32, rdy32}, {126'd0, 2'b01});
        @(posedge clock); #1;
        chk("flush_input_dropped", {127'd0, v32}, 128'd0);

        // Reset mid-stream.
        in_valid = 1'b1;
        in_inst  = 32'hFFF00093;
        in_pc    = 32'h3000;
        @(posedge clock); #1;
        in_inst = 32'h80000537;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset32", {v32, rdy32, inst32, pc32, imm32, t32}, {2'b00, 96'd0, 3'd0});
        chk("async_reset64", {v64, rdy64, t64, imm64}, {2'b00, 3'd0, 64'd0});
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            chk("no_glitch_after_reset", {126'd0, v32, rdy32}, {126'd0, 2'b01});
        end

        @(posedge clock); #1;
        out_ready = 1'b1;
        send(32'hFE000EE3, 32'h4000);
        send(32'h3050D073, 32'h4004);
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clock);
        @(negedge clock); #1;
        chk("drain", 128'(sb.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
